// File: rtl/lcd_bus_scheduler_if.sv
// Bundle of the two requester handshakes and the LCD pin-side outputs.
// The scheduler uses the slave view; sources and the bench use the master view.
interface lcd_bus_scheduler_if;
    logic       req0_valid;
    logic [9:0] req0_word;
    logic       req0_lock;
    logic       req0_ready;
    logic       req1_valid;
    logic [9:0] req1_word;
    logic       req1_lock;
    logic       req1_ready;
    logic [9:0] lcd_data;
    logic       lcd_e;
    logic       busy;
    logic [1:0] owner;

    modport master (
        output req0_valid, req0_word, req0_lock,
        input  req0_ready,
        output req1_valid, req1_word, req1_lock,
        input  req1_ready,
        input  lcd_data, lcd_e, busy, owner
    );

    modport slave (
        input  req0_valid, req0_word, req0_lock,
        output req0_ready,
        input  req1_valid, req1_word, req1_lock,
        output req1_ready,
        output lcd_data, lcd_e, busy, owner
    );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// Arbitrates the init and refresh word sources onto the 1602 LCD bus and
// runs one setup / E-pulse / hold / execution-wait cycle per accepted word.
module lcd_bus_scheduler #(
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_PW        = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 76000
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_bus_scheduler_if.slave bus
);

    localparam int unsigned T_MAX_A = (T_SETUP > T_PW) ? T_SETUP : T_PW;
    localparam int unsigned T_MAX_B = (T_MAX_A > T_HOLD) ? T_MAX_A : T_HOLD;
    localparam int unsigned T_MAX_C = (T_MAX_B > T_EXEC) ? T_MAX_B : T_EXEC;
    localparam int unsigned T_MAX   = (T_MAX_C > T_EXEC_LONG) ? T_MAX_C : T_EXEC_LONG;
    // +1 keeps the largest load value representable when it is a power of two
    localparam int unsigned CNT_W   = $clog2(T_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_SETUP = cnt_t'(T_SETUP);
    localparam cnt_t CNT_PW    = cnt_t'(T_PW);
    localparam cnt_t CNT_HOLD  = cnt_t'(T_HOLD);
    localparam cnt_t CNT_EXEC  = cnt_t'(T_EXEC);
    localparam cnt_t CNT_LONG  = cnt_t'(T_EXEC_LONG);
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t CNT_ZERO  = cnt_t'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4
    } state_t;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long(input logic [9:0] word);
        return (word[9:2] == 8'h00) && (word[1:0] != 2'b00);
    endfunction

    state_t     state_r, state_s;
    cnt_t       cnt_r, cnt_s;
    logic [9:0] lcd_data_r, lcd_data_s;
    logic       lcd_e_r, lcd_e_s;
    logic       busy_r, busy_s;
    logic [1:0] owner_r, owner_s;
    logic       long_r, long_s;

    logic       ready0_s, ready1_s;
    logic       accept0_s, accept1_s, accept_s;
    logic [9:0] acc_word_s;
    logic       acc_lock_s;
    logic       owner_release_s;
    logic       cnt_last_s;

    // Arbitration: the lock holder is the only candidate, otherwise requester 0 has priority.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            case (owner_r)
                2'b01: begin
                    ready0_s = 1'b1;
                    ready1_s = 1'b0;
                end
                2'b10: begin
                    ready0_s = 1'b0;
                    ready1_s = 1'b1;
                end
                default: begin
                    ready0_s = 1'b1;
                    ready1_s = ~bus.req0_valid;
                end
            endcase
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    assign accept0_s       = bus.req0_valid & ready0_s;
    assign accept1_s       = bus.req1_valid & ready1_s;
    assign accept_s        = accept0_s | accept1_s;
    assign acc_word_s      = accept0_s ? bus.req0_word : bus.req1_word;
    assign acc_lock_s      = accept0_s ? bus.req0_lock : bus.req1_lock;
    assign owner_release_s = (owner_r[0] & ~bus.req0_lock) | (owner_r[1] & ~bus.req1_lock);
    // <= also catches a zero count so a bad parameter cannot stall the sequence
    assign cnt_last_s      = (cnt_r <= CNT_ONE);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            lcd_data_r <= 10'h000;
            lcd_e_r    <= 1'b0;
            busy_r     <= 1'b0;
            owner_r    <= 2'b00;
            long_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            lcd_data_r <= lcd_data_s;
            lcd_e_r    <= lcd_e_s;
            busy_r     <= busy_s;
            owner_r    <= owner_s;
            long_r     <= long_s;
        end
    end

    // Next-state and down-counter sequencing of the strobe cycle.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SETUP;
                    cnt_s   = CNT_SETUP;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_SETUP: begin
                if (cnt_last_s) begin
                    state_s = ST_PULSE;
                    cnt_s   = CNT_PW;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_last_s) begin
                    state_s = ST_HOLD;
                    cnt_s   = CNT_HOLD;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_last_s) begin
                    state_s = ST_EXEC;
                    cnt_s   = long_r ? CNT_LONG : CNT_EXEC;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_EXEC: begin
                if (cnt_last_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output values for the next cycle: word latch, exec class, lock ownership, strobe.
    always_comb begin
        lcd_data_s = lcd_data_r;
        long_s     = long_r;
        owner_s    = owner_r;
        if (accept_s) begin
            lcd_data_s = acc_word_s;
            long_s     = is_long(acc_word_s);
            owner_s    = acc_lock_s ? (accept0_s ? 2'b01 : 2'b10) : 2'b00;
        end else if ((state_r == ST_IDLE) && owner_release_s) begin
            owner_s    = 2'b00;
        end else begin
            owner_s    = owner_r;
        end
        lcd_e_s = (state_s == ST_PULSE);
        busy_s  = (state_s != ST_IDLE);
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.lcd_data   = lcd_data_r;
    assign bus.lcd_e      = lcd_e_r;
    assign bus.busy       = busy_r;
    assign bus.owner      = owner_r;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed plus randomized bench for lcd_bus_scheduler; a transaction-level model
// predicts winner, acceptance cycle, strobe edges and ownership of every word.
module tb_lcd_bus_scheduler;
    localparam int S  = 2;
    localparam int P  = 12;
    localparam int H  = 2;
    localparam int E  = 40;
    localparam int EL = 300;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lcd_bus_scheduler_if bus();

    lcd_bus_scheduler #(
        .T_SETUP(S), .T_PW(P), .T_HOLD(H), .T_EXEC(E), .T_EXEC_LONG(EL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic       v [2];
    logic [9:0] w [2];
    logic       l [2];
    assign bus.req0_valid = v[0];
    assign bus.req0_word  = w[0];
    assign bus.req0_lock  = l[0];
    assign bus.req1_valid = v[1];
    assign bus.req1_word  = w[1];
    assign bus.req1_lock  = l[1];

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         rise_q[$];
    int         fall_q[$];
    logic       e_prev = 1'b0;
    int         prev_k = -1;
    logic [9:0] last_word = 10'h000;
    logic [1:0] model_owner = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe edge log, indexed by the clock edge that produced the change.
    always @(negedge clk) begin
        if (bus.lcd_e === 1'b1 && e_prev === 1'b0) rise_q.push_back(cyc);
        if (bus.lcd_e === 1'b0 && e_prev === 1'b1) fall_q.push_back(cyc);
        e_prev = bus.lcd_e;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exec_of(input logic [9:0] wd);
        if (wd[9:2] == 8'h00 && wd[1:0] != 2'b00) return EL;
        return E;
    endfunction

    function automatic int next_k();
        return prev_k + S + P + H + exec_of(last_word) + 1;
    endfunction

    function automatic logic [9:0] rand_word();
        int         sel;
        logic [9:0] x;
        sel = $urandom_range(0, 7);
        x   = 10'($urandom);
        if (sel == 0) return 10'h000;
        if (sel <= 2) return {8'h00, 2'($urandom_range(1, 3))};
        return x;
    endfunction

    task automatic wait_accept(output int id, output int k);
        id = -1;
        k  = -1;
        for (int n = 0; n < 1000 && id < 0; n++) begin
            @(negedge clk);
            if (v[0] && bus.req0_ready === 1'b1) id = 0;
            else if (v[1] && bus.req1_ready === 1'b1) id = 1;
        end
        if (id >= 0) begin
            k = cyc + 1;
            chk("idle_busy", bus.busy, 0);
            chk("idle_e", bus.lcd_e, 0);
            chk("idle_data", bus.lcd_data, last_word);
            if (id == 0) chk("r1_ready_during_r0", bus.req1_ready, 0);
        end
    endtask

    task automatic pop_strobe();
        int r;
        int f;
        r = -1;
        f = -1;
        if (rise_q.size() > 0) r = rise_q.pop_front();
        if (fall_q.size() > 0) f = fall_q.pop_front();
        chk("e_rise", r, prev_k + S);
        chk("e_fall", f, prev_k + S + P);
    endtask

    task automatic accept(input int exp_id, input logic [9:0] exp_word, input int exp_k);
        int         id;
        int         k;
        logic [1:0] exp_owner;
        wait_accept(id, k);
        chk("acc_id", id, exp_id);
        if (exp_k >= 0) chk("acc_cycle", k, exp_k);
        if (prev_k >= 0) pop_strobe();
        exp_owner = l[exp_id] ? ((exp_id == 0) ? 2'b01 : 2'b10) : 2'b00;
        @(negedge clk);
        chk("acc_data", bus.lcd_data, exp_word);
        chk("acc_busy", bus.busy, 1);
        chk("acc_owner", bus.owner, exp_owner);
        model_owner = exp_owner;
        prev_k      = (exp_k >= 0) ? exp_k : k;
        last_word   = exp_word;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy !== 1'b0 && n < 1000);
        chk("idle_reached", bus.busy, 0);
    endtask

    int         win;
    int         m;
    logic [9:0] bw;

    initial begin
        v[0] = 1'b0; v[1] = 1'b0;
        w[0] = 10'h000; w[1] = 10'h000;
        l[0] = 1'b0; l[1] = 1'b0;

        // reset values
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_data", bus.lcd_data, 0);
        chk("rst_e", bus.lcd_e, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_owner", bus.owner, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // single write and exact busy window
        v[1] = 1'b1; w[1] = 10'h210; l[1] = 1'b0;
        accept(1, 10'h210, -1);
        v[1] = 1'b0;
        w[1] = 10'h001;
        while (cyc < prev_k + S + P + H + E - 1) @(negedge clk);
        chk("busy_last_exec", bus.busy, 1);
        chk("data_held_exec", bus.lcd_data, 10'h210);
        v[1] = 1'b1;

        // clear, home, 0x000 spacing
        accept(1, 10'h001, next_k());
        w[1] = 10'h003;
        accept(1, 10'h003, next_k());
        w[1] = 10'h000;
        accept(1, 10'h000, next_k());
        w[1] = 10'h210;
        accept(1, 10'h210, next_k());

        // fixed priority
        v[0] = 1'b1; w[0] = 10'h038; l[0] = 1'b0;
        w[1] = 10'h0C0;
        accept(0, 10'h038, next_k());
        v[0] = 1'b0;
        accept(1, 10'h0C0, next_k());

        // 17-word lock burst with requester 0 pending
        bw = {2'b10, 8'($urandom)};
        w[1] = bw; l[1] = 1'b1;
        accept(1, bw, next_k());
        v[0] = 1'b1; w[0] = 10'h155; l[0] = 1'b0;
        for (int i = 2; i <= 17; i++) begin
            bw = {2'b10, 8'($urandom)};
            w[1] = bw;
            l[1] = (i < 17);
            accept(1, bw, next_k());
        end
        v[1] = 1'b0;
        accept(0, 10'h155, next_k());
        v[0] = 1'b0;

        // lock dropped while idle
        v[1] = 1'b1; w[1] = 10'h2A5; l[1] = 1'b1;
        accept(1, 10'h2A5, next_k());
        v[1] = 1'b0;
        v[0] = 1'b1; w[0] = 10'h00C; l[0] = 1'b0;
        wait_idle();
        chk("locked_owner", bus.owner, 2'b10);
        repeat (3) begin
            @(negedge clk);
            chk("locked_r0_ready", bus.req0_ready, 0);
        end
        m = cyc;
        l[1] = 1'b0;
        accept(0, 10'h00C, m + 2);

        // reset during the E pulse
        w[0] = 10'h0AB; l[0] = 1'b1;
        accept(0, 10'h0AB, next_k());
        v[0] = 1'b0;
        m = 0;
        while (bus.lcd_e !== 1'b1 && m < 100) begin
            @(negedge clk);
            m++;
        end
        chk("pulse_seen", bus.lcd_e, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_e", bus.lcd_e, 0);
        chk("arst_data", bus.lcd_data, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_owner", bus.owner, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rise_q.delete();
        fall_q.delete();
        prev_k = -1;
        last_word = 10'h000;
        model_owner = 2'b00;
        v[1] = 1'b1; w[1] = 10'h1C5; l[1] = 1'b0;
        accept(1, 10'h1C5, -1);

        // randomized arbitration, lock and exec-class traffic
        for (int r = 0; r < 24; r++) begin
            v[0] = 1'($urandom_range(0, 1));
            v[1] = 1'($urandom_range(0, 1));
            if (!v[0] && !v[1]) v[$urandom_range(0, 1)] = 1'b1;
            if (model_owner == 2'b01) v[0] = 1'b1;
            if (model_owner == 2'b10) v[1] = 1'b1;
            w[0] = rand_word();
            w[1] = rand_word();
            l[0] = ($urandom_range(0, 2) == 0);
            l[1] = ($urandom_range(0, 2) == 0);
            if (model_owner == 2'b10) win = 1;
            else if (model_owner == 2'b01) win = 0;
            else win = v[0] ? 0 : 1;
            accept(win, w[win], next_k());
        end

        // drain and check quiet idle
        v[0] = 1'b0; v[1] = 1'b0;
        l[0] = 1'b0; l[1] = 1'b0;
        wait_idle();
        pop_strobe();
        repeat (4) @(negedge clk);
        chk("quiet_busy", bus.busy, 0);
        chk("quiet_data", bus.lcd_data, last_word);
        chk("quiet_owner", bus.owner, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
